pcounter_ctrl: RTL
==================

# pcounter_ctrl

Multi-requester configuration controller for the `pcounter` block. Accepts word-level register operations from up to four requesters and arbitrates between them round-robin. Drives `pcounter`'s SRAM-like cfg port (`cfg_enable`/`cfg_rd_wr`/`cfg_addr`/`cfg_wdata`/`cfg_rdata`) one transaction at a time and returns a response per operation. Also provides a RESTART macro-op that atomically stops the counter, reloads its start value and restarts it.

## Interface
- `NREQ`, 2, number of requesters; legal range 2..4.
- `clk`  in  1  sole clock; all state updates on posedge.
- `rst`  in  1  synchronous, active-high reset.
- `req_valid`  in  NREQ  request valid, one bit per requester.
- `req_ready`  out  NREQ  one-hot accept; the op is accepted in a cycle where `req_valid[i] && req_ready[i]`.
- `req_op`  in  2*NREQ  op per requester, slice i at [2i+1:2i]: 00 WR, 01 RD, 10 RESTART, 11 reserved.
- `req_addr`  in  5*NREQ  pcounter register address per requester; ignored for RESTART.
- `req_wdata`  in  32*NREQ  write data, or the new min/start value for RESTART.
- `rsp_valid`  out  NREQ  one-cycle one-hot completion pulse to the owning requester.
- `rsp_rdata`  out  32  read data; 0 for non-RD ops and errors.
- `rsp_err`  out  1  error flag, qualified by `|rsp_valid`.
- `cfg_enable`, `cfg_rd_wr`, `cfg_addr[4:0]`, `cfg_wdata[31:0]`  out  pcounter cfg port; `cfg_rd_wr` is 1 for read, 0 for write.
- `cfg_rdata`  in  32  pcounter read data; registered inside pcounter, valid the cycle after a read strobe.
- `busy`  out  1  high whenever the state is not IDLE.

## Operation
- FSM states: IDLE, ISSUE, RD_WAIT, RS_STOP, RS_MIN, RS_START, RESP.
- IDLE: the arbiter grants one valid requester; `req_ready` is asserted only in IDLE. The controller latches op, addr, wdata and owner.
  - Legal WR/RD goes to ISSUE.
  - RESTART goes to RS_STOP.
  - Illegal op goes straight to RESP with `rsp_err=1`.
- Illegal ops:
  - reserved op code 11;
  - `addr[1:0]!=0`;
  - WR to 0x10 (ROLLOVER_STATUS) or 0x14 (COUNT).
  - Illegal ops produce no cfg strobe.
- ISSUE: drives `cfg_enable=1` for exactly one cycle.
  - WR: `cfg_rd_wr=0`, addr/wdata from the latched request, then RESP.
  - RD: `cfg_rd_wr=1`, then RD_WAIT.
- RD_WAIT: `cfg_enable=0`; latch `cfg_rdata` into the response register; then RESP.
- RESTART: each of the three states below issues one write strobe, in order.
  - RS_STOP writes 0 to 0x1C.
  - RS_MIN writes the latched wdata to 0x04, which also reloads count.
  - RS_START writes 1 to 0x1C.
  - Then RESP.
- RESP: `rsp_valid[owner]=1` for one cycle with `rsp_rdata`/`rsp_err`; then IDLE.
- Arbitration is round-robin over NREQ with a last-grant pointer.
  - Search starts at last+1 (mod NREQ).
  - The pointer updates only on accept.
  - Reset pointer is NREQ-1, so requester 0 wins first.
- A grant covers the whole op, including all three RESTART beats; no interleaving.
- Idle cfg drive: `cfg_enable=0`, `cfg_rd_wr=1`, `cfg_addr=0`, `cfg_wdata=0`.

## Timing
Counting the accept cycle as cycle 0:
- WR: strobe at cycle 1, `rsp_valid` at cycle 2.
- RD: strobe at cycle 1, capture at cycle 2, `rsp_valid` at cycle 3.
- RESTART: strobes at cycles 1, 2, 3; `rsp_valid` at cycle 4.
- Error: `rsp_valid` at cycle 1.

Other rules:
- The next accept is possible no earlier than the cycle after RESP.
- Requesters hold `req_valid` and payload stable until ready; dropping valid before ready is permitted and simply withdraws the request.
- Reset values:
  - state IDLE;
  - `req_ready=0` is combinational, so it is 0 throughout reset;
  - `rsp_valid=0`, `rsp_rdata=0`, `rsp_err=0`, `busy=0`;
  - cfg outputs at their idle values.
- Reset mid-op aborts the op:
  - no response is ever issued for it;
  - `cfg_enable` is 0 from the cycle after `rst` is sampled;
  - a partially completed RESTART is not rolled back.
- Simultaneous valids are resolved by round-robin; losers wait with `req_ready=0`.

## Structure
- Package `pcounter_ctrl_pkg`:
  - op enum (OP_WR, OP_RD, OP_RESTART);
  - FSM state enum;
  - address constants ADDR_DIR=0x00, ADDR_MIN=0x04, ADDR_MAX=0x08, ADDR_STEP=0x0C, ADDR_RSTAT=0x10, ADDR_COUNT=0x14, ADDR_RENA=0x18, ADDR_START=0x1C.
- Sub-module `pcounter_rr_arb`, parameterised on NREQ:
  - inputs: `req_valid`, `advance`;
  - outputs: one-hot `grant`, encoded `grant_id`;
  - holds the last-grant pointer.
- All cfg outputs and response outputs are registered.

## Test plan
1. After reset, req0 WR addr 0x08 wdata 100 -> one strobe at cycle 1 (`cfg_rd_wr=0`, addr 0x08, wdata 100); `rsp_valid[0]` at cycle 2 with `rsp_err=0`.
2. req1 RD addr 0x08 following scenario 1 -> `rsp_valid[1]` at cycle 3, `rsp_rdata=100`.
3. req0 and req1 valid in the same cycle, back to back for 4 ops -> grant order 0,1,0,1; never two ops overlapping.
4. RESTART wdata 7 with the counter running -> writes 0x1C=0, 0x04=7, 0x1C=1 on consecutive cycles; counter resumes from 7; `rsp_valid` at cycle 4.
5. WR to 0x14, WR to addr 0x05, and op 11 -> no cfg strobe; `rsp_err=1` one cycle after each accept.
6. Assert `rst` in the RS_MIN cycle -> no `rsp_valid`; `cfg_enable` stays 0 afterwards; `busy=0`; the next request is accepted normally with requester 0 prioritised.

Source files
------------

// File: rtl/pcounter_ctrl_pkg.sv
// Shared types and register map for the pcounter configuration controller.
// Holds the op/state enums, latched-request struct and op legality rule.
package pcounter_ctrl_pkg;

  typedef enum logic [1:0] {
    OP_WR      = 2'b00,
    OP_RD      = 2'b01,
    OP_RESTART = 2'b10,
    OP_RSVD    = 2'b11
  } op_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_RD_WAIT,
    S_RS_STOP,
    S_RS_MIN,
    S_RS_START,
    S_RESP
  } state_e;

  localparam logic [4:0] ADDR_DIR   = 5'h00;
  localparam logic [4:0] ADDR_MIN   = 5'h04;
  localparam logic [4:0] ADDR_MAX   = 5'h08;
  localparam logic [4:0] ADDR_STEP  = 5'h0C;
  localparam logic [4:0] ADDR_RSTAT = 5'h10;
  localparam logic [4:0] ADDR_COUNT = 5'h14;
  localparam logic [4:0] ADDR_RENA  = 5'h18;
  localparam logic [4:0] ADDR_START = 5'h1C;

  typedef struct packed {
    op_e         op;
    logic [4:0]  addr;
    logic [31:0] wdata;
  } req_t;

  // RESTART ignores its address, so alignment only matters for WR/RD.
  function automatic logic is_illegal(input logic [1:0] op, input logic [4:0] addr);
    logic bad;
    bad = 1'b0;
    if (op == OP_RSVD) begin
      bad = 1'b1;
    end else if (op != OP_RESTART && addr[1:0] != 2'b00) begin
      bad = 1'b1;
    end else if (op == OP_WR && (addr == ADDR_RSTAT || addr == ADDR_COUNT)) begin
      bad = 1'b1;
    end
    return bad;
  endfunction

endpackage

// File: rtl/pcounter_ctrl_rr_arb.sv
// Round-robin arbiter: combinational grant searching from last+1, pointer
// moves only when the grant is accepted (i_advance).
module pcounter_rr_arb
  import pcounter_ctrl_pkg::*;
#(
  parameter  int NREQ = 2,
  localparam int IDW  = (NREQ > 2) ? 2 : 1
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic [NREQ-1:0] i_req_valid,
  input  logic            i_advance,
  output logic [NREQ-1:0] o_grant,
  output logic [IDW-1:0]  o_grant_id
);

  logic [IDW-1:0] r_last;
  logic [IDW-1:0] w_idx;
  logic           w_found;

  always_comb begin
    o_grant    = '0;
    o_grant_id = '0;
    w_idx      = '0;
    w_found    = 1'b0;
    for (int k = 1; k <= NREQ; k++) begin
      w_idx = IDW'((int'(r_last) + k) % NREQ);
      if (!w_found && i_req_valid[w_idx]) begin
        w_found        = 1'b1;
        o_grant[w_idx] = 1'b1;
        o_grant_id     = w_idx;
      end
    end
  end

  // Reset to the top index so requester 0 is searched first.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_last <= IDW'(NREQ - 1);
    end else if (i_advance) begin
      r_last <= o_grant_id;
    end
  end

endmodule

// File: rtl/pcounter_ctrl.sv
// Multi-requester cfg controller for pcounter: one op at a time, RESTART as
// an atomic stop/reload/start write sequence, one-cycle response per op.
module pcounter_ctrl
  import pcounter_ctrl_pkg::*;
#(
  parameter int NREQ = 2
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [NREQ-1:0]   i_req_valid,
  output logic [NREQ-1:0]   o_req_ready,
  input  logic [2*NREQ-1:0] i_req_op,
  input  logic [5*NREQ-1:0] i_req_addr,
  input  logic [32*NREQ-1:0] i_req_wdata,
  output logic [NREQ-1:0]   o_rsp_valid,
  output logic [31:0]       o_rsp_rdata,
  output logic              o_rsp_err,
  output logic              o_cfg_enable,
  output logic              o_cfg_rd_wr,
  output logic [4:0]        o_cfg_addr,
  output logic [31:0]       o_cfg_wdata,
  input  logic [31:0]       i_cfg_rdata,
  output logic              o_busy
);

  localparam int IDW = (NREQ > 2) ? 2 : 1;

  state_e          r_state;
  state_e          w_state_nxt;
  req_t            r_req;
  req_t            w_in;
  req_t            w_req_nxt;
  logic [IDW-1:0]  r_owner;
  logic [IDW-1:0]  w_owner_nxt;
  logic [IDW-1:0]  w_grant_id;
  logic [NREQ-1:0] w_grant;
  logic [NREQ-1:0] w_owner_oh;
  logic            w_accept;
  logic            w_illegal;
  logic            w_cfg_en;
  logic            w_cfg_rd_wr;
  logic [4:0]      w_cfg_addr;
  logic [31:0]     w_cfg_wdata;

  pcounter_rr_arb #(.NREQ(NREQ)) u_arb (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_req_valid (i_req_valid),
    .i_advance   (w_accept),
    .o_grant     (w_grant),
    .o_grant_id  (w_grant_id)
  );

  assign o_req_ready = (r_state == S_IDLE && !i_rst) ? w_grant : '0;
  assign w_accept    = |(i_req_valid & o_req_ready);
  assign o_busy      = (r_state != S_IDLE);

  always_comb begin
    w_in.op     = op_e'(i_req_op[2*w_grant_id +: 2]);
    w_in.addr   = i_req_addr[5*w_grant_id +: 5];
    w_in.wdata  = i_req_wdata[32*w_grant_id +: 32];
    w_illegal   = is_illegal(w_in.op, w_in.addr);
    w_req_nxt   = w_accept ? w_in : r_req;
    w_owner_nxt = w_accept ? w_grant_id : r_owner;
    w_owner_oh  = '0;
    w_owner_oh[w_owner_nxt] = 1'b1;
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          if (w_illegal)                  w_state_nxt = S_RESP;
          else if (w_in.op == OP_RESTART) w_state_nxt = S_RS_STOP;
          else                            w_state_nxt = S_ISSUE;
        end
      end
      S_ISSUE:    w_state_nxt = (r_req.op == OP_RD) ? S_RD_WAIT : S_RESP;
      S_RD_WAIT:  w_state_nxt = S_RESP;
      S_RS_STOP:  w_state_nxt = S_RS_MIN;
      S_RS_MIN:   w_state_nxt = S_RS_START;
      S_RS_START: w_state_nxt = S_RESP;
      S_RESP:     w_state_nxt = S_IDLE;
      default:    w_state_nxt = S_IDLE;
    endcase
  end

  // cfg outputs are registered, so they are decoded from the state being entered.
  always_comb begin
    w_cfg_en    = 1'b0;
    w_cfg_rd_wr = 1'b1;
    w_cfg_addr  = '0;
    w_cfg_wdata = '0;
    unique case (w_state_nxt)
      S_ISSUE: begin
        w_cfg_en    = 1'b1;
        w_cfg_rd_wr = (w_req_nxt.op == OP_RD);
        w_cfg_addr  = w_req_nxt.addr;
        w_cfg_wdata = (w_req_nxt.op == OP_RD) ? 32'd0 : w_req_nxt.wdata;
      end
      S_RS_STOP: begin
        w_cfg_en    = 1'b1;
        w_cfg_rd_wr = 1'b0;
        w_cfg_addr  = ADDR_START;
        w_cfg_wdata = 32'd0;
      end
      S_RS_MIN: begin
        w_cfg_en    = 1'b1;
        w_cfg_rd_wr = 1'b0;
        w_cfg_addr  = ADDR_MIN;
        w_cfg_wdata = w_req_nxt.wdata;
      end
      S_RS_START: begin
        w_cfg_en    = 1'b1;
        w_cfg_rd_wr = 1'b0;
        w_cfg_addr  = ADDR_START;
        w_cfg_wdata = 32'd1;
      end
      default: begin
        w_cfg_en = 1'b0;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state      <= S_IDLE;
      r_req        <= '0;
      r_owner      <= '0;
      o_cfg_enable <= 1'b0;
      o_cfg_rd_wr  <= 1'b1;
      o_cfg_addr   <= '0;
      o_cfg_wdata  <= '0;
      o_rsp_valid  <= '0;
      o_rsp_rdata  <= '0;
      o_rsp_err    <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      o_cfg_enable <= w_cfg_en;
      o_cfg_rd_wr  <= w_cfg_rd_wr;
      o_cfg_addr   <= w_cfg_addr;
      o_cfg_wdata  <= w_cfg_wdata;
      if (w_accept) begin
        r_req   <= w_in;
        r_owner <= w_grant_id;
      end
      o_rsp_valid <= '0;
      o_rsp_rdata <= '0;
      o_rsp_err   <= 1'b0;
      // Only an illegal op jumps from IDLE straight to RESP.
      if (w_state_nxt == S_RESP) begin
        o_rsp_valid <= w_owner_oh;
        o_rsp_err   <= (r_state == S_IDLE);
        if (r_state == S_RD_WAIT) o_rsp_rdata <= i_cfg_rdata;
      end
    end
  end

endmodule
